fpu_scoreboard: RTL and testbench
=================================

// Module: fpu_scoreboard
// PURPOSE
//  Parametrised FP hazard unit for the decode/issue stage: per-register pending-write counters,
//  RAW/WAW stall generation and N-source operand forwarding for NREAD read ports.
//  Generalises single-stage FP forwarding to multi-cycle ops (fdiv/fsqrt, fma) completing out of order.
//  Sits between the FP register file read ports and the FP execute issue point.
// PARAMETERS
//  XLEN      32  operand width
//  NREAD     3   read ports (rs1/rs2/rs3)
//  NFWD      2   forwarding sources; index 0 = youngest, highest priority
//  MAX_PEND  3   max outstanding writes per register; counter width CW = $clog2(MAX_PEND+1)
// PORTS
//  clock      in   1            clock
//  reset      in   1            synchronous, active-high
//  iss_valid  in   1            instruction present at issue
//  iss_fwren  in   1            instruction writes an FP register
//  iss_waddr  in   5            destination register
//  iss_class  in   1            0 = fixed-latency pipe, 1 = iterative unit (fdiv/fsqrt)
//  iss_rden   in   NREAD        per-port read enable
//  iss_raddr  in   NREAD*5      per-port source register
//  rf_rdata   in   NREAD*XLEN   register file read data
//  fwd_valid  in   NFWD         forwarding source holds a final result
//  fwd_addr   in   NFWD*5       forwarding destination register
//  fwd_data   in   NFWD*XLEN    forwarding data
//  wb_valid   in   1            register file write this cycle (retires one pending write)
//  wb_waddr   in   5            register written
//  flush      in   1            discard all in-flight writes
//  stall      out  1            issue must hold (combinational)
//  opr_data   out  NREAD*XLEN   resolved operands (combinational)
//  busy       out  1            any counter nonzero (registered)
//  err        out  1            sticky: writeback to a register with zero pending
// BEHAVIOUR
//  - Reset: all counters 0, all class bits 0, err 0, busy 0. stall = 0 whenever iss_valid = 0.
//  - Port p ready if ~iss_rden[p], or pend[raddr]==0, or (pend[raddr]==1 and some fwd_valid[k]
//    with fwd_addr[k]==raddr). opr_data[p]: lowest matching k's fwd_data, else rf_rdata; 0 if ~rden.
//  - Forwarding is selected only when pend==1. Forwarding with pend==0 is stale and ignored.
//  - WAW check applies when iss_fwren = 1.
//    - Destination free if pend[waddr]==0.
//    - Also free if cls[waddr]==iss_class==0 and pend[waddr]<MAX_PEND.
//    - Iterative ops never overlap a pending write to the same register.
//  - stall = iss_valid & (any port not ready | (iss_fwren & destination not free)).
//  - iss_fire = iss_valid & ~stall & iss_fwren.
//    On fire: pend[waddr] += 1 and cls[waddr] <= iss_class, effective next cycle.
//  - wb_valid: pend[wb_waddr] -= 1.
//    If pend==0: counter stays 0 (no underflow) and err <= 1.
//  - Fire and wb to the same register in one cycle: count unchanged, cls updated.
//  - flush has priority over fire and wb in the same cycle: all counters 0 next cycle.
//    - cls is untouched; err is untouched except for the case below.
//    - wb arriving after the flush, for a register already at 0, sets err.
//    - The pipeline must squash in-flight writes itself.
//  - Counters saturate at MAX_PEND, which the WAW rule guarantees is never exceeded.
//  - busy <= (any counter nonzero next cycle).
//  - Reset mid-operation: all state cleared in the same cycle; pending writes are forgotten.
//  - Latency: stall and opr_data are combinational, 0 cycles; counters update 1 cycle after the event.
// STRUCTURE
//  - fp_wire: fp_scoreboard_in_type and fp_scoreboard_out_type.
//  - fp_cons: default MAX_PEND and the class encodings fp_class_pipe = 0, fp_class_iter = 1.
//  - Sub-module fpu_fwd_mux: one per read port, generate loop over NREAD; priority select over NFWD.
//  - Counter/class arrays live in this module as a single always_ff.
// TESTING
//  1. Reset, then iss_valid=1 rden[0]=1 raddr0=5 rf_rdata0=0x3F800000 -> stall=0, opr_data0=0x3F800000, busy=0.
//  2. Fire fdiv class1 waddr=3. Next cycle read f3 -> stall=1 for every cycle until wb_valid waddr=3.
//     Then pend=0, stall=0, read returns rf_rdata.
//  3. Fire fadd class0 waddr=7. Next cycle fwd_valid[1]=1 addr=7 data=0x40000000, read f7
//     -> stall=0, opr_data=0x40000000. If fwd_valid[0] also matches with data=0x40400000, that value is selected.
//  4. WAW: fire three fadd to f2 -> pend=3. A fourth fadd to f2 -> stall=1.
//     fsqrt to f2 while pend>0 -> stall=1. Three wb to f2 -> pend=0, busy=0.
//  5. Fire and wb to f4 in the same cycle with pend[4]=1 -> pend stays 1.
//     flush with pending f1,f4 -> busy=0 next cycle. A later wb to f4 -> err=1, and err stays 1 until reset.
//  6. Assert reset while pend[9]=2 and err=1 -> next cycle busy=0, err=0, read f9 -> stall=0.

Source files
------------

// File: rtl/fpu_scoreboard_pkg.sv
// Shared widths, class encodings and bus payload types for the FP hazard unit.
package fpu_scoreboard_pkg;

    // Geometry and operand width
    localparam int unsigned XLEN     = 32;
    localparam int unsigned NREAD    = 3;
    localparam int unsigned NFWD     = 2;
    localparam int unsigned MAX_PEND = 3;
    localparam int unsigned CW       = $clog2(MAX_PEND + 1);
    localparam int unsigned AW       = 5;
    localparam int unsigned NREG     = 32;

    // Issue class encodings
    localparam logic fp_class_pipe = 1'b0;
    localparam logic fp_class_iter = 1'b1;

    // Issue-side request: issue slot, RF read data, forwarding taps, writeback, flush
    typedef struct packed {
        logic                   iss_valid;
        logic                   iss_fwren;
        logic [AW-1:0]          iss_waddr;
        logic                   iss_class;
        logic [NREAD-1:0]       iss_rden;
        logic [NREAD*AW-1:0]    iss_raddr;
        logic [NREAD*XLEN-1:0]  rf_rdata;
        logic [NFWD-1:0]        fwd_valid;
        logic [NFWD*AW-1:0]     fwd_addr;
        logic [NFWD*XLEN-1:0]   fwd_data;
        logic                   wb_valid;
        logic [AW-1:0]          wb_waddr;
        logic                   flush;
    } fp_scoreboard_in_type;

    // Response: combinational stall/operands, registered busy/err
    typedef struct packed {
        logic                   stall;
        logic [NREAD*XLEN-1:0]  opr_data;
        logic                   busy;
        logic                   err;
    } fp_scoreboard_out_type;

endpackage

// File: rtl/fpu_scoreboard_if.sv
// Bundles the scoreboard request and response payloads.
interface fpu_scoreboard_if;
    import fpu_scoreboard_pkg::*;

    fp_scoreboard_in_type  req;
    fp_scoreboard_out_type rsp;

    modport master (output req, input  rsp);
    modport slave  (input  req, output rsp);
endinterface

// File: rtl/fpu_fwd_mux.sv
// Per read port operand select: youngest matching forward tap wins over RF data.
module fpu_fwd_mux #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NFWD = 2,
    parameter int unsigned AW   = 5
) (
    input  logic                 rden_i,
    input  logic                 fwd_en_i,
    input  logic [AW-1:0]        raddr_i,
    input  logic [XLEN-1:0]      rf_rdata_i,
    input  logic [NFWD-1:0]      fwd_valid_i,
    input  logic [NFWD*AW-1:0]   fwd_addr_i,
    input  logic [NFWD*XLEN-1:0] fwd_data_i,
    output logic                 fwd_hit_c_o,
    output logic [XLEN-1:0]      data_c_o
);

    logic [XLEN-1:0] fwd_sel_c;

    // Priority scan: lowest index is the youngest result and is taken first
    always_comb begin
        fwd_hit_c_o = 1'b0;
        fwd_sel_c   = '0;
        for (int unsigned k = 0; k < NFWD; k++) begin
            if (!fwd_hit_c_o && fwd_valid_i[k] && (fwd_addr_i[k*AW +: AW] == raddr_i)) begin
                fwd_hit_c_o = 1'b1;
                fwd_sel_c   = fwd_data_i[k*XLEN +: XLEN];
            end
        end
    end

    // Forwarded value only when the single outstanding write is the one on the tap
    always_comb begin
        data_c_o = '0;
        if (rden_i) begin
            data_c_o = (fwd_en_i && fwd_hit_c_o) ? fwd_sel_c : rf_rdata_i;
        end
    end

endmodule

// File: rtl/fpu_scoreboard.sv
// FP hazard unit: per-register pending-write counters, RAW/WAW stall and operand forwarding.
module fpu_scoreboard
    import fpu_scoreboard_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    fpu_scoreboard_if.slave sb_if
);

    fp_scoreboard_in_type  req;
    fp_scoreboard_out_type rsp_c;

    logic [NREG-1:0][CW-1:0]    pend_q, pend_d;
    logic [NREG-1:0]            cls_q, cls_d;
    logic                       err_q, err_d;
    logic                       busy_q, busy_d;

    logic [NREAD-1:0]           rdy_c;
    logic [NREAD-1:0]           hit_c;
    logic [NREAD-1:0][XLEN-1:0] opr_c;
    logic [CW-1:0]              pend_w_c;
    logic                       dst_free_c;
    logic                       stall_c;
    logic                       fire_c;

    assign req = sb_if.req;

    // One forwarding mux and RAW readiness term per read port
    for (genvar p = 0; p < NREAD; p++) begin : g_port
        logic [AW-1:0] raddr_c;
        logic          one_c;

        assign raddr_c = req.iss_raddr[p*AW +: AW];
        assign one_c   = (pend_q[raddr_c] == CW'(1));

        fpu_fwd_mux #(
            .XLEN (XLEN),
            .NFWD (NFWD),
            .AW   (AW)
        ) u_fwd_mux (
            .rden_i      (req.iss_rden[p]),
            .fwd_en_i    (one_c),
            .raddr_i     (raddr_c),
            .rf_rdata_i  (req.rf_rdata[p*XLEN +: XLEN]),
            .fwd_valid_i (req.fwd_valid),
            .fwd_addr_i  (req.fwd_addr),
            .fwd_data_i  (req.fwd_data),
            .fwd_hit_c_o (hit_c[p]),
            .data_c_o    (opr_c[p])
        );

        assign rdy_c[p] = ~req.iss_rden[p] | (pend_q[raddr_c] == '0) | (one_c & hit_c[p]);
    end

    // WAW: pipe ops may stack behind pipe ops up to the cap; iterative ops never overlap
    always_comb begin
        pend_w_c   = pend_q[req.iss_waddr];
        dst_free_c = (pend_w_c == '0)
                   | ((cls_q[req.iss_waddr] == fp_class_pipe)
                      && (req.iss_class == fp_class_pipe)
                      && (pend_w_c < CW'(MAX_PEND)));
        stall_c    = req.iss_valid & (~(&rdy_c) | (req.iss_fwren & ~dst_free_c));
        fire_c     = req.iss_valid & ~stall_c & req.iss_fwren;
    end

    // Next counter/class/err state; flush clears counters and overrides fire/wb
    always_comb begin
        pend_d = pend_q;
        cls_d  = cls_q;
        err_d  = err_q;
        busy_d = 1'b0;
        if (req.flush) begin
            pend_d = '0;
        end else begin
            if (fire_c) begin
                cls_d[req.iss_waddr] = req.iss_class;
            end
            for (int unsigned r = 0; r < NREG; r++) begin
                if (fire_c && (req.iss_waddr == AW'(r))
                        && !(req.wb_valid && (req.wb_waddr == AW'(r)))) begin
                    if (pend_q[r] != CW'(MAX_PEND)) begin
                        pend_d[r] = pend_q[r] + CW'(1);
                    end
                end else if (req.wb_valid && (req.wb_waddr == AW'(r))
                        && !(fire_c && (req.iss_waddr == AW'(r)))) begin
                    if (pend_q[r] != '0) begin
                        pend_d[r] = pend_q[r] - CW'(1);
                    end
                end
            end
            if (req.wb_valid && (pend_q[req.wb_waddr] == '0)) begin
                err_d = 1'b1;
            end
        end
        for (int unsigned r = 0; r < NREG; r++) begin
            busy_d = busy_d | (pend_d[r] != '0);
        end
    end

    // Counter, class, busy and sticky error state
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q <= '0;
            cls_q  <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cls_q  <= cls_d;
            err_q  <= err_d;
            busy_q <= busy_d;
        end
    end

    // Response assembly
    always_comb begin
        rsp_c          = '0;
        rsp_c.stall    = stall_c;
        rsp_c.opr_data = opr_c;
        rsp_c.busy     = busy_q;
        rsp_c.err      = err_q;
    end

    assign sb_if.rsp = rsp_c;

endmodule

// File: tb/tb_fpu_scoreboard.sv
// Directed bench for fpu_scoreboard with an expectation queue drained by a monitor.
module tb_fpu_scoreboard;
    import fpu_scoreboard_pkg::*;

    logic clock;
    logic reset;

    fpu_scoreboard_if sb ();

    fpu_scoreboard dut (
        .clock (clock),
        .reset (reset),
        .sb_if (sb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expectation record; m bits: 0 stall, 1 opr_data port 0, 2 busy, 3 err
    typedef struct {
        string       name;
        logic [3:0]  m;
        logic        stall;
        logic [31:0] opr;
        logic        busy;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        sb.req = '0;
    endtask

    task automatic rd0(input logic [4:0] a, input logic [31:0] d);
        sb.req.iss_valid      = 1'b1;
        sb.req.iss_rden[0]    = 1'b1;
        sb.req.iss_raddr[4:0] = a;
        sb.req.rf_rdata[31:0] = d;
    endtask

    task automatic wr(input logic [4:0] a, input logic c);
        sb.req.iss_valid = 1'b1;
        sb.req.iss_fwren = 1'b1;
        sb.req.iss_waddr = a;
        sb.req.iss_class = c;
    endtask

    task automatic fwd(input int k, input logic [4:0] a, input logic [31:0] d);
        sb.req.fwd_valid[k]         = 1'b1;
        sb.req.fwd_addr[k*5 +: 5]   = a;
        sb.req.fwd_data[k*32 +: 32] = d;
    endtask

    task automatic wb(input logic [4:0] a);
        sb.req.wb_valid = 1'b1;
        sb.req.wb_waddr = a;
    endtask

    task automatic chk(input string n, input logic [3:0] m, input logic s,
                       input logic [31:0] o, input logic b, input logic e);
        exp_t x;
        x.name = n; x.m = m; x.stall = s; x.opr = o; x.busy = b; x.err = e;
        exp_q.push_back(x);
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.m[0]) begin
                    n_total++;
                    if (sb.rsp.stall === e.stall) n_pass++;
                    else $display("FAIL %s stall: got %b want %b", e.name, sb.rsp.stall, e.stall);
                end
                if (e.m[1]) begin
                    n_total++;
                    if (sb.rsp.opr_data[31:0] === e.opr) n_pass++;
                    else $display("FAIL %s opr0: got %h want %h", e.name, sb.rsp.opr_data[31:0], e.opr);
                end
                if (e.m[2]) begin
                    n_total++;
                    if (sb.rsp.busy === e.busy) n_pass++;
                    else $display("FAIL %s busy: got %b want %b", e.name, sb.rsp.busy, e.busy);
                end
                if (e.m[3]) begin
                    n_total++;
                    if (sb.rsp.err === e.err) n_pass++;
                    else $display("FAIL %s err: got %b want %b", e.name, sb.rsp.err, e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        clr();
        step(); step();
        reset = 1'b0;

        // 1: plain read after reset
        clr(); rd0(5'd5, 32'h3F800000);
        chk("t1_read", 4'b1111, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        step();

        // 2: iterative write to f3 blocks readers until writeback
        clr(); wr(5'd3, fp_class_iter);
        chk("t2_fire", 4'b0101, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            clr(); rd0(5'd3, 32'h11111111);
            chk("t2_raw", 4'b0101, 1'b1, 32'h0, 1'b1, 1'b0);
            step();
        end
        clr(); rd0(5'd3, 32'h11111111); wb(5'd3);
        chk("t2_wbcyc", 4'b0001, 1'b1, 32'h0, 1'b0, 1'b0);
        step();
        clr(); rd0(5'd3, 32'h11111111);
        chk("t2_free", 4'b1111, 1'b0, 32'h11111111, 1'b0, 1'b0);
        step();

        // 3: forwarding from taps, youngest wins, stale tap ignored
        clr(); wr(5'd7, fp_class_pipe);
        chk("t3_fire", 4'b0001, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        clr(); rd0(5'd7, 32'h77777777); fwd(1, 5'd7, 32'h40000000);
        chk("t3_fwd1", 4'b0111, 1'b0, 32'h40000000, 1'b1, 1'b0);
        step();
        clr(); rd0(5'd7, 32'h77777777); fwd(1, 5'd7, 32'h40000000); fwd(0, 5'd7, 32'h40400000);
        chk("t3_fwd0", 4'b0011, 1'b0, 32'h40400000, 1'b0, 1'b0);
        step();
        clr(); rd0(5'd5, 32'h55555555); fwd(0, 5'd5, 32'hDEADBEEF);
        chk("t3_stale", 4'b0011, 1'b0, 32'h55555555, 1'b0, 1'b0);
        step();
        clr(); wb(5'd7);
        step();
        clr();
        chk("t3_idle", 4'b0100, 1'b0, 32'h0, 1'b0, 1'b0);
        step();

        // 4: WAW limits on f2
        for (int i = 0; i < 3; i++) begin
            clr(); wr(5'd2, fp_class_pipe);
            chk("t4_stack", 4'b0001, 1'b0, 32'h0, 1'b0, 1'b0);
            step();
        end
        clr(); wr(5'd2, fp_class_pipe);
        chk("t4_cap", 4'b0101, 1'b1, 32'h0, 1'b1, 1'b0);
        step();
        clr(); wr(5'd2, fp_class_iter);
        chk("t4_iter", 4'b0001, 1'b1, 32'h0, 1'b0, 1'b0);
        step();
        clr(); rd0(5'd2, 32'h22222222); fwd(0, 5'd2, 32'hCAFEF00D);
        chk("t4_rawfwd", 4'b0001, 1'b1, 32'h0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            clr(); wb(5'd2);
            chk("t4_drain", 4'b0101, 1'b0, 32'h0, 1'b1, 1'b0);
            step();
        end
        clr();
        chk("t4_empty", 4'b1100, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        clr(); wr(5'd2, fp_class_iter);
        chk("t4_iterfree", 4'b0001, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        clr(); wr(5'd2, fp_class_pipe);
        chk("t4_behinditer", 4'b0101, 1'b1, 32'h0, 1'b1, 1'b0);
        step();
        clr(); wb(5'd2);
        step();

        // 5: fire+wb same register, flush, late writeback error
        clr(); wr(5'd4, fp_class_pipe);
        chk("t5_fire", 4'b0101, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        clr(); wr(5'd4, fp_class_pipe); wb(5'd4);
        chk("t5_firewb", 4'b0001, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        clr(); rd0(5'd4, 32'h44444444);
        chk("t5_pend1raw", 4'b0101, 1'b1, 32'h0, 1'b1, 1'b0);
        step();
        clr(); rd0(5'd4, 32'h44444444); fwd(1, 5'd4, 32'h12345678);
        chk("t5_pend1fwd", 4'b0011, 1'b0, 32'h12345678, 1'b0, 1'b0);
        step();
        clr(); wr(5'd1, fp_class_pipe);
        step();
        clr(); sb.req.flush = 1'b1;
        chk("t5_preflush", 4'b0100, 1'b0, 32'h0, 1'b1, 1'b0);
        step();
        clr();
        chk("t5_flushed", 4'b1100, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        clr(); wb(5'd4);
        step();
        for (int i = 0; i < 3; i++) begin
            clr();
            chk("t5_err", 4'b1100, 1'b0, 32'h0, 1'b0, 1'b1);
            step();
        end

        // 6: reset clears pending writes and the sticky error
        clr(); wr(5'd9, fp_class_pipe);
        step();
        clr(); wr(5'd9, fp_class_pipe);
        chk("t6_second", 4'b0001, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        clr(); rd0(5'd9, 32'h99999999);
        chk("t6_before", 4'b1101, 1'b1, 32'h0, 1'b1, 1'b1);
        step();
        clr(); reset = 1'b1;
        step();
        reset = 1'b0;
        clr(); rd0(5'd9, 32'h99999999);
        chk("t6_after", 4'b1111, 1'b0, 32'h99999999, 1'b0, 1'b0);
        step();

        clr();
        step(); step();
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
